mem_bus_arbiter: RTL and testbench

Two-master arbiter that shares the platform MemoryBus (the path into the slave bus mux and data memory) between the debug probe (master A) and the CPU core's data port (master B). It replaces a static select with a registered request/grant handshake, fixed priority for the probe, and a starvation guard so the CPU cannot be locked out indefinitely. Slave-side outputs drive the slave bus mux command directly; read data is routed back combinationally to the granted master.

---
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 104 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// MemoryBus between the two masters, the arbiter and the slave bus mux.
// slave: the arbiter's view; master: the surrounding masters and slave mux.
interface mem_bus_arbiter_if;
  logic        req_a;
  logic        req_b;
  logic [29:0] a_address;
  logic [29:0] b_address;
  logic        a_mem_read;
  logic        b_mem_read;
  logic        a_mem_write;
  logic        b_mem_write;
  logic [3:0]  a_mask_byte;
  logic [3:0]  b_mask_byte;
  logic [31:0] a_write_data;
  logic [31:0] b_write_data;
  logic        gnt_a;
  logic        gnt_b;
  logic [31:0] a_read_data;
  logic [31:0] b_read_data;
  logic [29:0] s_address;
  logic        s_mem_read;
  logic        s_mem_write;
  logic [3:0]  s_mask_byte;
  logic [31:0] s_write_data;
  logic [31:0] s_read_data;
  logic        starve_switch;

  modport slave (
    input  req_a, req_b, a_address, b_address, a_mem_read, b_mem_read,
           a_mem_write, b_mem_write, a_mask_byte, b_mask_byte,
           a_write_data, b_write_data, s_read_data,
    output gnt_a, gnt_b, a_read_data, b_read_data, s_address, s_mem_read,
           s_mem_write, s_mask_byte, s_write_data, starve_switch
  );

  modport master (
    output req_a, req_b, a_address, b_address, a_mem_read, b_mem_read,
           a_mem_write, b_mem_write, a_mask_byte, b_mask_byte,
           a_write_data, b_write_data, s_read_data,
    input  gnt_a, gnt_b, a_read_data, b_read_data, s_address, s_mem_read,
           s_mem_write, s_mask_byte, s_write_data, starve_switch
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master MemoryBus arbiter: probe (A) has fixed priority, a wait counter
// forces a hand-over when the non-owner has been held off for MAX_WAIT cycles.
module mem_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
  localparam bit GUARD_EN = (MAX_WAIT != 0);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          starve_q, starve_d;
  logic          guard_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  // Counter only advances while contended and is cleared on any state change,
  // so the forced switch always happens before it could overflow.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    starve_d  = 1'b0;
    guard_hit = GUARD_EN && (wait_q == WAIT_LAST);
    unique case (state_q)
      IDLE: begin
        if (bus.req_a)      state_d = OWN_A;
        else if (bus.req_b) state_d = OWN_B;
      end
      OWN_A: begin
        if (!bus.req_a) begin
          state_d = bus.req_b ? OWN_B : IDLE;
        end else if (bus.req_b) begin
          if (guard_hit) begin
            state_d  = OWN_B;
            starve_d = 1'b1;
          end else if (GUARD_EN) begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      OWN_B: begin
        if (!bus.req_b) begin
          state_d = bus.req_a ? OWN_A : IDLE;
        end else if (bus.req_a) begin
          if (guard_hit) begin
            state_d  = OWN_A;
            starve_d = 1'b1;
          end else if (GUARD_EN) begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt_a         = (state_q == OWN_A);
    bus.gnt_b         = (state_q == OWN_B);
    bus.starve_switch = starve_q;
    bus.s_address     = '0;
    bus.s_mem_read    = 1'b0;
    bus.s_mem_write   = 1'b0;
    bus.s_mask_byte   = '0;
    bus.s_write_data  = '0;
    bus.a_read_data   = '0;
    bus.b_read_data   = '0;
    unique case (state_q)
      OWN_A: begin
        bus.s_address    = bus.a_address;
        bus.s_mem_read   = bus.a_mem_read & bus.req_a;
        bus.s_mem_write  = bus.a_mem_write & bus.req_a;
        bus.s_mask_byte  = bus.a_mask_byte;
        bus.s_write_data = bus.a_write_data;
        bus.a_read_data  = bus.s_read_data;
      end
      OWN_B: begin
        bus.s_address    = bus.b_address;
        bus.s_mem_read   = bus.b_mem_read & bus.req_b;
        bus.s_mem_write  = bus.b_mem_write & bus.req_b;
        bus.s_mask_byte  = bus.b_mask_byte;
        bus.s_write_data = bus.b_write_data;
        bus.b_read_data  = bus.s_read_data;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances (MAX_WAIT 16, 4, 0) share one
// stimulus set; a word memory behind the MAX_WAIT=16 instance models the slave.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_a, req_b, a_rd, b_rd, a_wr, b_wr;
  logic [29:0] a_address, b_address;
  logic [3:0]  a_mask, b_mask;
  logic [31:0] a_wdata, b_wdata;

  mem_bus_arbiter_if if16();
  mem_bus_arbiter_if if4();
  mem_bus_arbiter_if if0();

  assign {if16.req_a, if16.req_b, if16.a_address, if16.b_address} = {req_a, req_b, a_address, b_address};
  assign {if16.a_mem_read, if16.b_mem_read, if16.a_mem_write, if16.b_mem_write} = {a_rd, b_rd, a_wr, b_wr};
  assign {if16.a_mask_byte, if16.b_mask_byte, if16.a_write_data, if16.b_write_data} = {a_mask, b_mask, a_wdata, b_wdata};
  assign {if4.req_a, if4.req_b, if4.a_address, if4.b_address} = {req_a, req_b, a_address, b_address};
  assign {if4.a_mem_read, if4.b_mem_read, if4.a_mem_write, if4.b_mem_write} = {a_rd, b_rd, a_wr, b_wr};
  assign {if4.a_mask_byte, if4.b_mask_byte, if4.a_write_data, if4.b_write_data} = {a_mask, b_mask, a_wdata, b_wdata};
  assign {if0.req_a, if0.req_b, if0.a_address, if0.b_address} = {req_a, req_b, a_address, b_address};
  assign {if0.a_mem_read, if0.b_mem_read, if0.a_mem_write, if0.b_mem_write} = {a_rd, b_rd, a_wr, b_wr};
  assign {if0.a_mask_byte, if0.b_mask_byte, if0.a_write_data, if0.b_write_data} = {a_mask, b_mask, a_wdata, b_wdata};

  mem_bus_arbiter #(.MAX_WAIT(16)) u16 (.clk(clk), .rst(rst), .bus(if16));
  mem_bus_arbiter #(.MAX_WAIT(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
  mem_bus_arbiter #(.MAX_WAIT(0))  u0  (.clk(clk), .rst(rst), .bus(if0));

  logic [31:0] mem [0:1023];
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= (i == 256) ? 32'hDEADBEEF : 32'h0;
    end else if (if16.s_mem_write) begin
      for (int j = 0; j < 4; j++)
        if (if16.s_mask_byte[j]) mem[if16.s_address[9:0]][8*j +: 8] <= if16.s_write_data[8*j +: 8];
    end
  end

  assign if16.s_read_data = mem[if16.s_address[9:0]];
  assign if4.s_read_data  = 32'h0BADF00D;
  assign if0.s_read_data  = 32'h0BADF00D;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  gnt_q[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {req_a, req_b, a_rd, b_rd, a_wr, b_wr} = '0;
    a_address = '0; b_address = '0; a_mask = '0; b_mask = '0;
    a_wdata = '0; b_wdata = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    idle_inputs();
    mem_clr = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    cyc(); cyc();
    mem_clr = 1'b0;
    checks++;
    if ({if16.gnt_a, if16.gnt_b, if16.starve_switch, if16.s_mem_read, if16.s_mem_write} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {if16.gnt_a, if16.gnt_b, if16.starve_switch, if16.s_mem_read, if16.s_mem_write});
    end
    rst = 1'b1;
    cyc();
    req_b = 1'b1; b_wr = 1'b1; b_address = 30'h55; b_wdata = 32'h12345678; b_mask = 4'hF;
    cyc();
    checks++;
    if ({if16.gnt_b, if16.s_mem_write} !== 2'b11) begin
      errors++;
      $display("FAIL reset_pre_own_b: got %b want 11", {if16.gnt_b, if16.s_mem_write});
    end
    exp_q.push_back(32'h0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({if16.gnt_b, if16.s_mem_write, if16.s_address != 30'h0} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: got gnt_b=%b s_mem_write=%b s_address=%h want 0", if16.gnt_b, if16.s_mem_write, if16.s_address);
    end
    cyc();
    idle_inputs();
    cyc();
    rst = 1'b1;
    cyc(); cyc();
    checks++;
    if ({if16.gnt_a, if16.gnt_b, if16.starve_switch, if16.s_mem_read, if16.s_mem_write} !== 5'b0 ||
        if16.a_read_data !== 32'h0 || if16.b_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_release_idle: got ctrl=%b a_rd=%h b_rd=%h want all 0",
               {if16.gnt_a, if16.gnt_b, if16.starve_switch, if16.s_mem_read, if16.s_mem_write}, if16.a_read_data, if16.b_read_data);
    end
    exp = exp_q.pop_front();
    checks++;
    if (mem[10'h55] !== exp) begin
      errors++;
      $display("FAIL reset_no_write: got mem[55]=%h want %h", mem[10'h55], exp);
    end
  endtask

  task automatic test_single();
    int unsigned n;
    logic [31:0] exp;
    b_address = 30'h100; b_rd = 1'b1; req_b = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!if16.gnt_b && n < 8);
    checks++;
    if (n != 1 || if16.gnt_b !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles gnt_b=%b want 1 cycle", n, if16.gnt_b);
    end
    exp = exp_q.pop_front();
    checks++;
    if (if16.b_read_data !== exp) begin
      errors++;
      $display("FAIL single_rdata: got %h want %h", if16.b_read_data, exp);
    end
    checks++;
    if (if16.a_read_data !== 32'h0 || if16.gnt_a !== 1'b0) begin
      errors++;
      $display("FAIL single_other: got a_rd=%h gnt_a=%b want 0", if16.a_read_data, if16.gnt_a);
    end
    checks++;
    if (if16.s_address !== 30'h100 || if16.s_mem_read !== 1'b1) begin
      errors++;
      $display("FAIL single_cmd: got addr=%h rd=%b want 100 1", if16.s_address, if16.s_mem_read);
    end
    req_b = 1'b0;
    #1;
    checks++;
    if (if16.s_mem_read !== 1'b0 || if16.gnt_b !== 1'b1) begin
      errors++;
      $display("FAIL single_req_gate: got rd=%b gnt_b=%b want 0 1", if16.s_mem_read, if16.gnt_b);
    end
    cyc();
    checks++;
    if ({if16.gnt_a, if16.gnt_b} !== 2'b00) begin
      errors++;
      $display("FAIL single_release: got %b want 00", {if16.gnt_a, if16.gnt_b});
    end
    idle_inputs();
  endtask

  task automatic test_tie();
    req_a = 1'b1; req_b = 1'b1;
    cyc();
    checks++;
    if ({if16.gnt_a, if16.gnt_b} !== 2'b10) begin
      errors++;
      $display("FAIL tie_first: got %b want 10", {if16.gnt_a, if16.gnt_b});
    end
    cyc(); cyc();
    checks++;
    if ({if16.gnt_a, if16.gnt_b} !== 2'b10) begin
      errors++;
      $display("FAIL tie_hold: got %b want 10", {if16.gnt_a, if16.gnt_b});
    end
    req_a = 1'b0;
    cyc();
    checks++;
    if ({if16.gnt_a, if16.gnt_b, if16.starve_switch} !== 3'b010) begin
      errors++;
      $display("FAIL tie_handover: got %b want 010", {if16.gnt_a, if16.gnt_b, if16.starve_switch});
    end
    req_b = 1'b0;
    cyc();
    checks++;
    if ({if16.gnt_a, if16.gnt_b} !== 2'b00) begin
      errors++;
      $display("FAIL tie_idle: got %b want 00", {if16.gnt_a, if16.gnt_b});
    end
  endtask

  task automatic test_starve();
    logic [2:0] exp;
    bit own_a, pulse;
    int unsigned pulses = 0;
    req_a = 1'b1; req_b = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      own_a = (((k - 1) / 4) % 2) == 0;
      pulse = (k > 1) && (((k - 1) % 4) == 0);
      gnt_q.push_back({own_a, !own_a, pulse});
      cyc();
      exp = gnt_q.pop_front();
      if (if4.starve_switch === 1'b1) pulses++;
      checks++;
      if ({if4.gnt_a, if4.gnt_b, if4.starve_switch} !== exp) begin
        errors++;
        $display("FAIL starve_cycle%0d: got %b want %b", k, {if4.gnt_a, if4.gnt_b, if4.starve_switch}, exp);
      end
    end
    checks++;
    if (pulses != 9) begin
      errors++;
      $display("FAIL starve_pulses: got %0d want 9", pulses);
    end
    idle_inputs();
    cyc(); cyc();
  endtask

  task automatic test_guard_off();
    logic [2:0] exp;
    req_a = 1'b1; req_b = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      gnt_q.push_back(3'b100);
      cyc();
      exp = gnt_q.pop_front();
      checks++;
      if ({if0.gnt_a, if0.gnt_b, if0.starve_switch} !== exp) begin
        errors++;
        $display("FAIL guard_off_cycle%0d: got %b want %b", k, {if0.gnt_a, if0.gnt_b, if0.starve_switch}, exp);
      end
    end
    idle_inputs();
    cyc(); cyc();
  endtask

  task automatic test_write_iso();
    logic [31:0] exp;
    req_a = 1'b1; a_rd = 1'b1; a_address = 30'h20; a_mask = 4'hF;
    req_b = 1'b1; b_wr = 1'b1; b_address = 30'h30; b_wdata = 32'hBAD0BAD0; b_mask = 4'hF;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hA5A5A5A5);
    cyc();
    checks++;
    if (if16.gnt_a !== 1'b1 || if16.s_mem_write !== 1'b0 || if16.s_address !== 30'h20) begin
      errors++;
      $display("FAIL iso_b_blocked: got gnt_a=%b wr=%b addr=%h want 1 0 20", if16.gnt_a, if16.s_mem_write, if16.s_address);
    end
    a_rd = 1'b0; a_wr = 1'b1; a_wdata = 32'hA5A5A5A5;
    #1;
    checks++;
    if (if16.s_mem_write !== 1'b1 || if16.s_write_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL iso_a_write: got wr=%b data=%h want 1 a5a5a5a5", if16.s_mem_write, if16.s_write_data);
    end
    cyc();
    idle_inputs();
    cyc();
    exp = exp_q.pop_front();
    checks++;
    if (mem[10'h30] !== exp) begin
      errors++;
      $display("FAIL iso_mem_b: got %h want %h", mem[10'h30], exp);
    end
    exp = exp_q.pop_front();
    checks++;
    if (mem[10'h20] !== exp) begin
      errors++;
      $display("FAIL iso_mem_a: got %h want %h", mem[10'h20], exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_starve();
    test_guard_off();
    test_write_iso();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
